mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 25 ++
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Two-port requester bus plus memory-side bus of mem_arbiter.
// The arbiter uses the slave modport; the environment (requesters + memory) uses master.
interface mem_arbiter_if;
    logic        req0, req1;
    logic        we0, we1;
    logic [31:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        done0, done1;
    logic        err;
    logic [31:0] rdata;
    logic        mem_re, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_ready,
        output done0, done1, err, rdata, mem_re, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_ready,
        input  done0, done1, err, rdata, mem_re, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter (IDLE -> ACCESS -> RESP) with a 16-cycle wait timeout.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking instead of fixed port-0 priority.
module mem_arbiter (
    input  logic          clk,
    input  logic          nrst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        win;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // prio_q names the port that wins the next tie
    logic prio_q, prio_d;

    always_comb begin
        if (bus.req0 && bus.req1) win = prio_q;
        else                      win = bus.req1 && !bus.req0;
    end

    always_comb begin
        prio_d = prio_q;
        if (state_q == IDLE && (bus.req0 || bus.req1)) prio_d = ~win;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) prio_q <= 1'b0;
        else       prio_q <= prio_d;
    end
`else
    assign win = bus.req1 && !bus.req0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    owner_d = win;
                    we_d    = win ? bus.we1    : bus.we0;
                    addr_d  = win ? bus.addr1  : bus.addr0;
                    wdata_d = win ? bus.wdata1 : bus.wdata0;
                    cnt_d   = 4'd0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // ready wins over the timeout when both land on the last wait cycle
                if (bus.mem_ready) begin
                    rdata_d = bus.mem_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == 4'd15) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.mem_re    = (state_q == ACCESS) && !we_q;
    assign bus.mem_we    = (state_q == ACCESS) &&  we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.done0     = (state_q == RESP) && !owner_q;
    assign bus.done1     = (state_q == RESP) &&  owner_q;
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: read, contention, timeout, boundary ready, reset abort, stray ready.
module tb_mem_arbiter;
    logic clk;
    logic nrst;
    int   checks;
    int   errors;
    logic [31:0] exp_rdata;
    int   we_cycles;
    logic got_done;

    mem_arbiter_if bus_if ();

    mem_arbiter dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // call right after entering ACCESS: waits cycles without ready, then one with ready
    task automatic finish_access(input int waits, input logic [31:0] rd);
        for (int i = 0; i < waits; i++) tick();
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = rd;
        tick();
        bus_if.mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        #1;
    endtask

    initial begin
        logic exp_port2;
        checks = 0;
        errors = 0;
        bus_if.req0 = 0; bus_if.req1 = 0; bus_if.we0 = 0; bus_if.we1 = 0;
        bus_if.addr0 = 0; bus_if.addr1 = 0; bus_if.wdata0 = 0; bus_if.wdata1 = 0;
        bus_if.mem_rdata = 0; bus_if.mem_ready = 0;
        nrst = 1'b0;
        #12;
        chk("rst_re",    {31'b0, bus_if.mem_re}, 0);
        chk("rst_we",    {31'b0, bus_if.mem_we}, 0);
        chk("rst_done",  {30'b0, bus_if.done1, bus_if.done0}, 0);
        chk("rst_err",   {31'b0, bus_if.err}, 0);
        chk("rst_rdata", bus_if.rdata, 0);
        chk("rst_addr",  bus_if.mem_addr, 0);
        chk("rst_wdata", bus_if.mem_wdata, 0);
        @(negedge clk);
        nrst = 1'b1;

        // single read
        tick();
        bus_if.req0 = 1; bus_if.we0 = 0; bus_if.addr0 = 32'h10;
        tick();
        chk("rd_re",   {31'b0, bus_if.mem_re}, 1);
        chk("rd_we",   {31'b0, bus_if.mem_we}, 0);
        chk("rd_addr", bus_if.mem_addr, 32'h10);
        chk("rd_done_early", {31'b0, bus_if.done0}, 0);
        finish_access(0, 32'hDEADBEEF);
        exp_rdata = 32'hDEADBEEF;
        chk("rd_done0", {31'b0, bus_if.done0}, 1);
        chk("rd_done1", {31'b0, bus_if.done1}, 0);
        chk("rd_rdata", bus_if.rdata, exp_rdata);
        chk("rd_err",   {31'b0, bus_if.err}, 0);
        chk("rd_resp_re", {31'b0, bus_if.mem_re}, 0);
        bus_if.req0 = 0;
        tick();
        chk("rd_done_one", {31'b0, bus_if.done0}, 0);

        // contention; reset first so the round-robin pointer starts at port 0
        do_reset();
        exp_rdata = 0;
        bus_if.req0 = 1; bus_if.we0 = 1; bus_if.addr0 = 32'h20; bus_if.wdata0 = 32'hA0A0A0A0;
        bus_if.req1 = 1; bus_if.we1 = 0; bus_if.addr1 = 32'h30;
        tick();
        chk("ct1_addr",  bus_if.mem_addr, 32'h20);
        chk("ct1_we",    {31'b0, bus_if.mem_we}, 1);
        chk("ct1_wdata", bus_if.mem_wdata, 32'hA0A0A0A0);
        tick();
        chk("ct1_hold",  bus_if.mem_addr, 32'h20);
        finish_access(1, 32'h11111111);
        exp_rdata = 32'h11111111;
        chk("ct1_done", {30'b0, bus_if.done1, bus_if.done0}, 2'b01);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        exp_port2 = 1'b1;
`else
        exp_port2 = 1'b0;
`endif
        tick();
        tick();
        chk("ct2_addr", bus_if.mem_addr, exp_port2 ? 32'h30 : 32'h20);
        finish_access(2, 32'h22222222);
        exp_rdata = 32'h22222222;
        chk("ct2_done", {30'b0, bus_if.done1, bus_if.done0}, exp_port2 ? 2'b10 : 2'b01);
        if (exp_port2) bus_if.req1 = 0; else bus_if.req0 = 0;
        tick();
        tick();
        chk("ct3_addr", bus_if.mem_addr, exp_port2 ? 32'h20 : 32'h30);
        finish_access(2, 32'h33333333);
        exp_rdata = 32'h33333333;
        chk("ct3_done", {30'b0, bus_if.done1, bus_if.done0}, exp_port2 ? 2'b01 : 2'b10);
        chk("ct3_rdata", bus_if.rdata, exp_rdata);
        bus_if.req0 = 0; bus_if.req1 = 0;
        tick();

        // timeout on port 1 write
        bus_if.req1 = 1; bus_if.we1 = 1; bus_if.addr1 = 32'h100; bus_if.wdata1 = 32'h12345678;
        bus_if.mem_rdata = 32'hBADBAD00;
        tick();
        chk("to_addr",  bus_if.mem_addr, 32'h100);
        chk("to_wdata", bus_if.mem_wdata, 32'h12345678);
        we_cycles = 0;
        got_done = 0;
        for (int i = 0; i < 40 && !got_done; i++) begin
            if (bus_if.mem_we) we_cycles++;
            if (bus_if.done1) got_done = 1;
            else tick();
        end
        chk("to_done",  {31'b0, got_done}, 1);
        chk("to_cycles", we_cycles, 16);
        chk("to_err",   {31'b0, bus_if.err}, 1);
        chk("to_rdata", bus_if.rdata, exp_rdata);
        bus_if.req1 = 0;
        tick();
        chk("to_err_hold", {31'b0, bus_if.err}, 1);

        // ready on the 16th ACCESS cycle
        bus_if.req0 = 1; bus_if.we0 = 0; bus_if.addr0 = 32'h40;
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("bd_re16", {31'b0, bus_if.mem_re}, 1);
        chk("bd_nodone", {31'b0, bus_if.done0}, 0);
        finish_access(0, 32'hCAFEF00D);
        exp_rdata = 32'hCAFEF00D;
        chk("bd_done", {31'b0, bus_if.done0}, 1);
        chk("bd_err",  {31'b0, bus_if.err}, 0);
        chk("bd_rdata", bus_if.rdata, exp_rdata);
        bus_if.req0 = 0;
        tick();

        // reset during 2nd ACCESS cycle
        bus_if.req0 = 1; bus_if.we0 = 0; bus_if.addr0 = 32'h50;
        tick();
        tick();
        chk("ra_re_pre", {31'b0, bus_if.mem_re}, 1);
        #2 nrst = 1'b0;
        #1;
        chk("ra_re",   {31'b0, bus_if.mem_re}, 0);
        chk("ra_done", {30'b0, bus_if.done1, bus_if.done0}, 0);
        chk("ra_rdata", bus_if.rdata, 0);
        chk("ra_addr", bus_if.mem_addr, 0);
        @(posedge clk);
        #1;
        chk("ra_done_hold", {30'b0, bus_if.done1, bus_if.done0}, 0);
        @(negedge clk);
        nrst = 1'b1;
        tick();
        chk("ra_regrant", {31'b0, bus_if.mem_re}, 1);
        chk("ra_addr2", bus_if.mem_addr, 32'h50);
        finish_access(1, 32'h5A5A5A5A);
        chk("ra_done2", {31'b0, bus_if.done0}, 1);
        chk("ra_rdata2", bus_if.rdata, 32'h5A5A5A5A);
        bus_if.req0 = 0;
        tick();

        // stray ready in IDLE
        bus_if.mem_ready = 1; bus_if.mem_rdata = 32'hFFFF0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sr_strobe", {30'b0, bus_if.mem_re, bus_if.mem_we}, 0);
            chk("sr_done",   {30'b0, bus_if.done1, bus_if.done0}, 0);
        end
        chk("sr_rdata", bus_if.rdata, 32'h5A5A5A5A);
        bus_if.req0 = 1; bus_if.we0 = 0; bus_if.addr0 = 32'h60;
        tick();
        chk("sr_access", {31'b0, bus_if.mem_re}, 1);
        tick();
        chk("sr_done2", {31'b0, bus_if.done0}, 1);
        chk("sr_rdata2", bus_if.rdata, 32'hFFFF0000);
        bus_if.req0 = 0; bus_if.mem_ready = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
